regfile_wr_arbiter: RTL

- Shares the single register-file write port between NREQ writeback sources (e.g. ALU result, load data, multiply/divide unit).
- Arbitration is round-robin. The winning request is registered and driven to the register file as a one-cycle write strobe with address and data.
- Sits between the writeback stage and the register file. Its write strobe is decoded by the register file into per-register write enables.

---
 rtl/regfile_wr_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the single register-file
// write port between NREQ writeback sources. The winning request is
// registered and presented as a one-cycle write strobe with address and data.
// Writes to register 0 are accepted but never strobed.
// Optional macro REGARB_PERF_EN adds saturating grant/stall counters.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wr_hold,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [W-1:0]         wr_data,
  output logic                 busy
`ifdef REGARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int              PW     = $clog2(NREQ);
  localparam logic [PW:0]     NREQ_X = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST   = PW'(NREQ-1);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [2*NREQ-1:0] rot;
  logic [PW:0]       sum;
  logic              found;
  logic [PW-1:0]     gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     sel_addr;
  logic [W-1:0]      sel_data;

  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [W-1:0]      wr_data_q, wr_data_d;

  // Rotate requests so the search starts at ptr; map first hit back to an absolute index.
  always_comb begin
    rot     = {req_valid, req_valid} >> ptr_q;
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= NREQ_X) sum = sum - NREQ_X;
        gnt_idx = sum[PW-1:0];
      end
    end
    gnt = '0;
    if (found && !rst && !wr_hold) gnt[gnt_idx] = 1'b1;
  end

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*W +: W];
      end
    end
  end

  // Next-state for the priority pointer and write-port registers.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (|gnt) begin
      ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
      wr_en_d   = |sel_addr;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req_ready = gnt;
  assign busy      = (|req_valid) & ~(|gnt);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

`ifdef REGARB_PERF_EN
  logic [15:0] gcnt_q [NREQ];
  logic [15:0] stall_q;

  // Saturating per-requester grant counters and busy-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
      if (busy && stall_q != '1) stall_q <= stall_q + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = gcnt_q[g];
  end
  assign stall_cnt = stall_q;
`endif

endmodule
